// File: rtl/fifo_rd_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_packer_pkg
//  Purpose  : Shared defaults and the lane-mask helper for the FIFO read-side
//             packer and its output register.
//  Contents : DEF_DSIZE, DEF_NBYTES  - default lane width / lanes per word
//             lane_below()           - 1 when a lane index lies below a count
//  Revision : 1.0  initial release
// ============================================================================
package fifo_rd_packer_pkg;

    localparam int unsigned DEF_DSIZE  = 8;
    localparam int unsigned DEF_NBYTES = 4;

    // A lane is populated in a partial word when its index is below the
    // number of lanes captured so far.
    function automatic logic lane_below(input logic [31:0] lane,
                                        input logic [31:0] count);
        return (lane < count);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_outreg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_outreg
//  Purpose  : Single-entry valid/ready holding register. A word loaded while
//             the slot is free is presented until the consumer accepts it.
//  Ports    : clk, rst        clock / asynchronous active-high reset
//             i_load          capture i_word (only asserted when o_slot_free)
//             i_word          word to capture
//             i_ready         consumer accepts o_word this edge when o_valid
//             o_word, o_valid registered word and its valid flag
//             o_slot_free     register empty or draining this cycle
//  Revision : 1.0  initial release
// ============================================================================
module fifo_rd_outreg #(
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid,
    output logic             o_slot_free
);

    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;

    assign o_slot_free = !valid_q || i_ready;
    assign o_word      = word_q;
    assign o_valid     = valid_q;

    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        if (i_load) begin
            word_d  = i_word;
            valid_d = 1'b1;
        end else if (i_ready) begin
            // Transfer with nothing behind it empties the slot; the word
            // itself is left in place.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_packer
//  Purpose  : Pops DSIZE-bit entries from a show-ahead FIFO read port and packs
//             NBYTES of them into one wide valid/ready word. A flush pulse
//             emits any buffered partial word with a lane-keep mask.
//  Ports    : rclk, rrst       read clock / asynchronous active-high reset
//             rdata, rempty    FIFO head entry and empty flag
//             rinc             pop strobe back to the FIFO
//             flush            one-cycle request to emit a partial word
//             o_data, o_keep,  packed word (lane 0 = first popped entry),
//             o_last, o_valid  lane mask, flush marker, valid
//             o_ready          downstream accept
//  Revision : 1.0  initial release
// ============================================================================
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DSIZE  = DEF_DSIZE,
    parameter int NBYTES = DEF_NBYTES
) (
    input  logic                     rclk,
    input  logic                     rrst,
    input  logic [DSIZE-1:0]         rdata,
    input  logic                     rempty,
    output logic                     rinc,
    input  logic                     flush,
    output logic [DSIZE*NBYTES-1:0]  o_data,
    output logic [NBYTES-1:0]        o_keep,
    output logic                     o_last,
    output logic                     o_valid,
    input  logic                     o_ready
);

    localparam int WSIZE = DSIZE * NBYTES;
    localparam int PSIZE = WSIZE - DSIZE;       // lanes 0..NBYTES-2
    localparam int OSIZE = WSIZE + NBYTES + 1;  // {last, keep, data}
    localparam int CW    = $clog2(NBYTES);
    localparam logic [CW-1:0] LAST_LANE = CW'(NBYTES - 1);

    logic [PSIZE-1:0]  pack_q, pack_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              flush_pend_q, flush_pend_d;

    logic              w_slot_free;
    logic              w_load;
    logic [OSIZE-1:0]  w_word_in;
    logic [OSIZE-1:0]  w_word_out;
    logic [WSIZE-1:0]  w_part_data;
    logic [NBYTES-1:0] w_part_keep;

    // The final lane may only be popped when the output slot can take the
    // completed word; earlier lanes never depend on downstream.
    assign rinc = !rrst && !rempty && !flush_pend_q &&
                  !((cnt_q == LAST_LANE) && !w_slot_free);

    always_comb begin
        pack_d       = pack_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q || flush;
        w_load       = 1'b0;
        w_word_in    = '0;
        w_part_data  = '0;
        w_part_keep  = '0;

        for (int i = 0; i < NBYTES - 1; i++) begin
            if (lane_below(32'(i), 32'(cnt_q))) begin
                w_part_data[i*DSIZE +: DSIZE] = pack_q[i*DSIZE +: DSIZE];
                w_part_keep[i]                = 1'b1;
            end
        end

        if (rinc) begin
            if (cnt_q == LAST_LANE) begin
                // Final lane goes straight from rdata into the output word.
                w_load    = 1'b1;
                w_word_in = {1'b0, {NBYTES{1'b1}}, rdata, pack_q};
                cnt_d     = '0;
            end else begin
                for (int i = 0; i < NBYTES - 1; i++) begin
                    if (cnt_q == CW'(i)) begin
                        pack_d[i*DSIZE +: DSIZE] = rdata;
                    end
                end
                cnt_d = cnt_q + 1'b1;
            end
        end else if (flush_pend_q && w_slot_free) begin
            // Pops are blocked while a flush is pending, so this branch is
            // never shared with a pop. An empty buffer just retires the flush.
            flush_pend_d = 1'b0;
            cnt_d        = '0;
            if (cnt_q != '0) begin
                w_load    = 1'b1;
                w_word_in = {1'b1, w_part_keep, w_part_data};
            end
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            pack_q       <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            pack_q       <= pack_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    fifo_rd_outreg #(
        .WIDTH (OSIZE)
    ) u_outreg (
        .clk         (rclk),
        .rst         (rrst),
        .i_load      (w_load),
        .i_word      (w_word_in),
        .i_ready     (o_ready),
        .o_word      (w_word_out),
        .o_valid     (o_valid),
        .o_slot_free (w_slot_free)
    );

    assign o_data = w_word_out[WSIZE-1:0];
    assign o_keep = w_word_out[WSIZE +: NBYTES];
    assign o_last = w_word_out[OSIZE-1];

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_packer
//  Purpose  : Self-checking bench for fifo_rd_packer (DSIZE=8, NBYTES=4):
//             fixed vector table, directed multi-cycle sequences, and random
//             traffic against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_rd_packer;

    logic        rclk = 1'b0;
    logic        rrst;
    logic [7:0]  rdata;
    logic        rempty;
    logic        rinc;
    logic        flush;
    logic [31:0] o_data;
    logic [3:0]  o_keep;
    logic        o_last;
    logic        o_valid;
    logic        o_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 rclk = ~rclk;

    fifo_rd_packer #(
        .DSIZE  (8),
        .NBYTES (4)
    ) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rdata   (rdata),
        .rempty  (rempty),
        .rinc    (rinc),
        .flush   (flush),
        .o_data  (o_data),
        .o_keep  (o_keep),
        .o_last  (o_last),
        .o_valid (o_valid),
        .o_ready (o_ready)
    );

    typedef struct {
        bit          e;
        logic [7:0]  d;
        bit          fl;
        bit          rdy;
        bit          x_rinc;
        bit          x_valid;
        logic [31:0] x_data;
        logic [3:0]  x_keep;
        bit          x_last;
    } vec_t;

    vec_t vecs [25];

    // Reference model: bytes popped into the current word, pending flush,
    // and the word the output register should be presenting.
    logic [7:0]  m_buf [$];
    logic [7:0]  src_q [$];
    bit          m_pend;
    bit          m_ov;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    bit          m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_buf();
        logic [31:0] r = '0;
        for (int i = 0; i < m_buf.size(); i++) r |= 32'(m_buf[i]) << (8 * i);
        return r;
    endfunction

    task automatic model_clear();
        m_buf.delete();
        m_pend = 0; m_ov = 0; m_data = '0; m_keep = '0; m_last = 0;
    endtask

    // One clock cycle of model-checked traffic. Called at posedge+1,
    // returns at the following posedge+1.
    task automatic cycle(input bit e, input bit fl, input bit rdy);
        bit          free, x_rinc, load;
        logic [31:0] nd;
        logic [3:0]  nk;
        bit          nl;
        if (src_q.size() == 0) src_q.push_back(8'($urandom));
        rempty = e; flush = fl; o_ready = rdy; rdata = src_q[0];
        #1;
        free   = !m_ov || rdy;
        x_rinc = !e && !m_pend && !(m_buf.size() == 3 && !free);
        chk("rinc", rinc, x_rinc);
        chk("o_valid", o_valid, m_ov);
        if (m_ov) begin
            chk("o_data", o_data, m_data);
            chk("o_keep", o_keep, m_keep);
            chk("o_last", o_last, m_last);
        end
        load = 0; nd = '0; nk = '0; nl = 0;
        if (x_rinc) begin
            m_buf.push_back(src_q.pop_front());
            if (m_buf.size() == 4) begin
                nd = pack_buf(); nk = 4'hF; nl = 0; load = 1;
                m_buf.delete();
            end
        end else if (m_pend && free) begin
            m_pend = 0;
            if (m_buf.size() > 0) begin
                nd = pack_buf(); nk = 4'((1 << m_buf.size()) - 1); nl = 1; load = 1;
                m_buf.delete();
            end
        end
        if (fl) m_pend = 1;
        if (load) begin
            m_ov = 1; m_data = nd; m_keep = nk; m_last = nl;
        end else if (rdy) begin
            m_ov = 0;
        end
        @(posedge rclk); #1;
        flush = 0;
    endtask

    task automatic do_reset();
        rrst = 1; rempty = 1; flush = 0; o_ready = 1;
        @(posedge rclk); #1;
        rrst = 0;
        model_clear();
        src_q.delete();
    endtask

    initial begin
        vecs[0]  = '{0, 8'h11, 0, 1, 1, 0, 32'h0, 4'h0, 0};
        vecs[1]  = '{1, 8'h22, 0, 1, 0, 0, 32'h0, 4'h0, 0};
        vecs[2]  = '{0, 8'h22, 0, 1, 1, 0, 32'h0, 4'h0, 0};
        vecs[3]  = '{1, 8'h33, 0, 1, 0, 0, 32'h0, 4'h0, 0};
        vecs[4]  = '{0, 8'h33, 0, 1, 1, 0, 32'h0, 4'h0, 0};
        vecs[5]  = '{1, 8'h44, 0, 1, 0, 0, 32'h0, 4'h0, 0};
        vecs[6]  = '{0, 8'h44, 0, 1, 1, 0, 32'h0, 4'h0, 0};
        vecs[7]  = '{1, 8'h00, 0, 1, 0, 1, 32'h44332211, 4'hF, 0};
        vecs[8]  = '{1, 8'h00, 0, 1, 0, 0, 32'h0, 4'h0, 0};
        vecs[9]  = '{0, 8'hA1, 0, 1, 1, 0, 32'h0, 4'h0, 0};
        vecs[10] = '{0, 8'hB2, 1, 1, 1, 0, 32'h0, 4'h0, 0};
        vecs[11] = '{0, 8'hC3, 0, 1, 0, 0, 32'h0, 4'h0, 0};
        vecs[12] = '{0, 8'hC3, 0, 1, 1, 1, 32'h0000B2A1, 4'h3, 1};
        vecs[13] = '{1, 8'h00, 0, 1, 0, 0, 32'h0, 4'h0, 0};
        vecs[14] = '{0, 8'hD4, 0, 1, 1, 0, 32'h0, 4'h0, 0};
        vecs[15] = '{0, 8'hE5, 0, 1, 1, 0, 32'h0, 4'h0, 0};
        vecs[16] = '{0, 8'hF6, 1, 1, 1, 0, 32'h0, 4'h0, 0};
        vecs[17] = '{0, 8'h07, 0, 1, 0, 1, 32'hF6E5D4C3, 4'hF, 0};
        vecs[18] = '{0, 8'h07, 0, 1, 1, 0, 32'h0, 4'h0, 0};
        vecs[19] = '{1, 8'h00, 1, 1, 0, 0, 32'h0, 4'h0, 0};
        vecs[20] = '{1, 8'h00, 0, 1, 0, 0, 32'h0, 4'h0, 0};
        vecs[21] = '{1, 8'h00, 1, 1, 0, 1, 32'h00000007, 4'h1, 1};
        vecs[22] = '{0, 8'h08, 0, 1, 0, 0, 32'h0, 4'h0, 0};
        vecs[23] = '{0, 8'h08, 0, 1, 1, 0, 32'h0, 4'h0, 0};
        vecs[24] = '{1, 8'h00, 0, 1, 0, 0, 32'h0, 4'h0, 0};

        // Reset held with data available: no pops, empty output.
        rrst = 1; rempty = 0; rdata = 8'h11; flush = 0; o_ready = 1;
        model_clear();
        @(posedge rclk); #1;
        chk("rst_rinc", rinc, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_keep", o_keep, 0);
        chk("rst_data", o_data, 0);
        chk("rst_last", o_last, 0);
        rrst = 0;

        // Vector table: packing across empty gaps, partial flush, flush at
        // word completion, flush with nothing buffered.
        for (int i = 0; i < 25; i++) begin
            rempty = vecs[i].e; rdata = vecs[i].d;
            flush = vecs[i].fl; o_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_rinc", i), rinc, vecs[i].x_rinc);
            chk($sformatf("vec%0d_valid", i), o_valid, vecs[i].x_valid);
            if (vecs[i].x_valid) begin
                chk($sformatf("vec%0d_data", i), o_data, vecs[i].x_data);
                chk($sformatf("vec%0d_keep", i), o_keep, vecs[i].x_keep);
                chk($sformatf("vec%0d_last", i), o_last, vecs[i].x_last);
            end
            @(posedge rclk); #1;
        end
        flush = 0;

        // Backpressure: first word held, three more lanes fill, final lane
        // waits for the slot and pops on the transfer edge.
        do_reset();
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h10 + i));
        for (int i = 0; i < 9; i++) cycle(0, 0, 0);
        chk("bp_hold_valid", o_valid, 1);
        chk("bp_hold_data", o_data, 32'h13121110);
        chk("bp_stall_rinc", rinc, 0);
        cycle(0, 0, 1);
        chk("bp_word1_valid", o_valid, 1);
        chk("bp_word1_data", o_data, 32'h17161514);
        cycle(1, 0, 1);

        // Asynchronous reset mid-word discards the buffered lanes.
        do_reset();
        src_q.push_back(8'h20); src_q.push_back(8'h21);
        cycle(0, 0, 1); cycle(0, 0, 1);
        #2 rrst = 1;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_rinc", rinc, 0);
        chk("midrst_keep", o_keep, 0);
        chk("midrst_data", o_data, 0);
        model_clear();
        src_q.delete();
        @(posedge rclk); #1;
        rrst = 0;
        for (int i = 1; i <= 4; i++) src_q.push_back(8'(i));
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);
        chk("postrst_valid", o_valid, 1);
        chk("postrst_data", o_data, 32'h04030201);
        chk("postrst_keep", o_keep, 4'hF);
        cycle(1, 0, 1);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit e, rdy, fl;
            e   = ($urandom_range(0, 9) < 3);
            rdy = ($urandom_range(0, 9) < 6);
            fl  = !m_pend && ($urandom_range(0, 19) == 0);
            cycle(e, fl, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
